// File: rtl/bcd_counter_pkg.sv
// Shared constants and helpers for the four-decade BCD counter.
package bcd_counter_pkg;

  localparam logic [3:0] DIGIT_MAX        = 4'd9;
  localparam logic [3:0] DIGIT_MIN        = 4'd0;
  localparam int         TICK_DIV_DEFAULT = 100_000_000;

  // Nibbles that are not valid BCD are forced to zero on load.
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] nib);
    return (nib > DIGIT_MAX) ? DIGIT_MIN : nib;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the counter: registered digit with combinational carry/borrow out.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       step_in,
  input  logic       up_down,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] digit,
  output logic       step_out
);

  assign step_out = step_in & (up_down ? (digit == DIGIT_MAX) : (digit == DIGIT_MIN));

  always_ff @(posedge clk_100MHz) begin
    if (reset || clear)
      digit <= DIGIT_MIN;
    else if (load)
      digit <= bcd_sanitize(load_digit);
    else if (step_in) begin
      if (up_down)
        digit <= (digit >= DIGIT_MAX) ? DIGIT_MIN : digit + 4'd1;
      else
        digit <= (digit == DIGIT_MIN || digit > DIGIT_MAX) ? DIGIT_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Four-digit up/down BCD counter with start/stop toggle, prescaled step tick,
// clear, load and a one-cycle rollover pulse on wrap.
module bcd_counter
  import bcd_counter_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        up_down,
  output logic [3:0]  ones,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic [3:0]  thousands,
  output logic        running,
  output logic        rollover
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);

  logic          start_prev;
  logic [PW-1:0] presc;
  logic          tick;
  logic          step;
  logic [3:0][3:0] dig;
  logic [4:0]    chain;

  assign tick = running & (presc == TICK_LAST);
  // A tick landing on a clear or load cycle is dropped entirely.
  assign step = tick & ~clear & ~load;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      start_prev <= 1'b0;
      running    <= 1'b0;
    end else begin
      start_prev <= start_stop;
      if (start_stop && !start_prev)
        running <= ~running;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset || clear || load)
      presc <= '0;
    else if (running)
      presc <= tick ? '0 : presc + PW'(1);
  end

  assign chain[0] = step;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_digit
      bcd_digit u_digit (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .step_in    (chain[g]),
        .up_down    (up_down),
        .clear      (clear),
        .load       (load),
        .load_digit (load_value[4*g +: 4]),
        .digit      (dig[g]),
        .step_out   (chain[g+1])
      );
    end
  endgenerate

  always_ff @(posedge clk_100MHz) begin
    if (reset)
      rollover <= 1'b0;
    else
      rollover <= chain[4];
  end

  assign ones      = dig[0];
  assign tens      = dig[1];
  assign hundreds  = dig[2];
  assign thousands = dig[3];

endmodule

// File: tb/tb_bcd_counter.sv
// Directed bench for bcd_counter with TICK_DIV=4; inputs change 1ns after a rising edge.
module tb_bcd_counter;

  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic        up_down = 1'b1;
  logic [3:0]  ones, tens, hundreds, thousands;
  logic        running, rollover;

  int checks = 0;
  int failures = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  bcd_counter #(.TICK_DIV(4)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .start_stop (start_stop),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .up_down    (up_down),
    .ones       (ones),
    .tens       (tens),
    .hundreds   (hundreds),
    .thousands  (thousands),
    .running    (running),
    .rollover   (rollover)
  );

  wire [15:0] digits = {thousands, hundreds, tens, ones};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_value = v;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("rst_digits", digits, 16'h0000);
    chk("rst_running", running, 0);
    chk("rst_rollover", rollover, 0);
    reset = 1'b0;
    cyc(1);

    // run from reset
    start_stop = 1'b1;
    cyc(1);
    chk("run_rise", running, 1);
    start_stop = 1'b0;
    cyc(3);
    chk("pre_first_tick", digits, 16'h0000);
    cyc(1);
    chk("first_tick", digits, 16'h0001);
    cyc(4);
    chk("second_tick", digits, 16'h0002);
    chk("still_running", running, 1);

    // up wrap
    do_load(16'h9999);
    chk("load_9999", digits, 16'h9999);
    cyc(3);
    chk("pre_wrap_up", {rollover, digits}, {1'b0, 16'h9999});
    cyc(1);
    chk("wrap_up", digits, 16'h0000);
    chk("wrap_up_roll", rollover, 1);
    cyc(1);
    chk("wrap_up_roll_off", rollover, 0);

    // down wrap
    up_down = 1'b0;
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clear", digits, 16'h0000);
    cyc(4);
    chk("wrap_down", digits, 16'h9999);
    chk("wrap_down_roll", rollover, 1);
    cyc(4);
    chk("down_9998", digits, 16'h9998);
    chk("down_no_roll", rollover, 0);

    // carry / borrow chain
    up_down = 1'b1;
    do_load(16'h0199);
    cyc(4);
    chk("carry_0200", digits, 16'h0200);
    up_down = 1'b0;
    do_load(16'h1000);
    cyc(4);
    chk("borrow_0999", digits, 16'h0999);

    // invalid nibble and clear+load on a tick cycle
    do_load(16'h12A4);
    chk("load_sanitize", digits, 16'h1204);
    cyc(3);
    clear = 1'b1;
    load = 1'b1;
    load_value = 16'h5555;
    cyc(1);
    clear = 1'b0;
    load = 1'b0;
    chk("clr_ld_tick", digits, 16'h0000);
    chk("clr_ld_no_roll", rollover, 0);
    up_down = 1'b1;
    cyc(3);
    chk("presc_zeroed", digits, 16'h0000);
    cyc(1);
    chk("after_clr_tick", digits, 16'h0001);

    // stop: digits freeze
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
    chk("stopped", running, 0);
    cyc(10);
    chk("frozen", digits, 16'h0001);
    chk("still_stopped", running, 0);

    // held high toggles only once; prescaler resumes from its held value
    start_stop = 1'b1;
    cyc(1);
    chk("restart", running, 1);
    cyc(9);
    chk("held_one_toggle", running, 1);
    chk("resume_count", digits, 16'h0003);
    start_stop = 1'b0;
    cyc(1);

    // reset mid-count with a tick pending
    reset = 1'b1;
    cyc(1);
    chk("midrst_digits", digits, 16'h0000);
    chk("midrst_running", running, 0);
    chk("midrst_roll", rollover, 0);
    start_stop = 1'b1;
    reset = 1'b0;
    cyc(1);
    chk("high_after_reset", running, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
